// File: rtl/pipeline_reg_decode_fwd.sv
// Decode-to-execute pipeline register with priority-ordered operand forwarding,
// load-use bubble insertion, external stall/flush and a saturating bubble counter.
module pipeline_reg_decode_fwd #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_in,
  input  logic                    flush_in,
  input  logic                    valid_in,
  input  logic                    write_enable_in,
  input  logic [4:0]              rd_sel_in,
  input  logic [4:0]              rs1_sel_in,
  input  logic [4:0]              rs2_sel_in,
  input  logic [XLEN-1:0]         rs1_value_in,
  input  logic [XLEN-1:0]         rs2_value_in,
  input  logic [XLEN-1:0]         mux_result_in,
  input  logic [6:0]              opcode_in,
  input  logic [6:0]              funct7_in,
  input  logic [2:0]              funct3_in,
  input  logic [NUM_FWD-1:0]      fwd_valid_in,
  input  logic [NUM_FWD-1:0]      fwd_pending_in,
  input  logic [5*NUM_FWD-1:0]    fwd_rd_sel_in,
  input  logic [XLEN*NUM_FWD-1:0] fwd_value_in,
  output logic                    valid_out,
  output logic                    write_enable_out,
  output logic [XLEN-1:0]         rs1_value_out,
  output logic [XLEN-1:0]         rs2_value_out,
  output logic [XLEN-1:0]         mux_result_out,
  output logic [6:0]              opcode_out,
  output logic [6:0]              funct7_out,
  output logic [4:0]              rd_sel_out,
  output logic [2:0]              funct3_out,
  output logic                    hazard_stall_out,
  output logic [CNT_W-1:0]        stall_cycles_out
);

  logic [XLEN:0]    rs1_res_s;
  logic [XLEN:0]    rs2_res_s;
  logic             hazard_s;

  logic             valid_r;
  logic             write_enable_r;
  logic [XLEN-1:0]  rs1_value_r;
  logic [XLEN-1:0]  rs2_value_r;
  logic [XLEN-1:0]  mux_result_r;
  logic [6:0]       opcode_r;
  logic [6:0]       funct7_r;
  logic [4:0]       rd_sel_r;
  logic [2:0]       funct3_r;
  logic [CNT_W-1:0] stall_cycles_r;

  // Returns {hazard, value}; the first matching source decides, even when it is still pending.
  function automatic logic [XLEN:0] resolve_operand(input logic [4:0] sel,
                                                    input logic [XLEN-1:0] rf_val);
    logic          found;
    logic [XLEN:0] res;
    found = 1'b0;
    res   = {1'b0, rf_val};
    if (sel != 5'd0) begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && fwd_valid_in[i] && (fwd_rd_sel_in[5*i +: 5] == sel)) begin
          found = 1'b1;
          if (fwd_pending_in[i]) begin
            res = {1'b1, rf_val};
          end else begin
            res = {1'b0, fwd_value_in[XLEN*i +: XLEN]};
          end
        end else begin
          found = found;
        end
      end
    end else begin
      res = {1'b0, rf_val};
    end
    return res;
  endfunction

  // Operand resolution and the zero-latency freeze request.
  always_comb begin
    rs1_res_s = resolve_operand(rs1_sel_in, rs1_value_in);
    rs2_res_s = resolve_operand(rs2_sel_in, rs2_value_in);
    hazard_s  = valid_in & ~flush_in & ~stall_in & (rs1_res_s[XLEN] | rs2_res_s[XLEN]);
  end

  // Pipeline slot update: reset, flush, hold, hazard bubble, then normal load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r        <= 1'b0;
      write_enable_r <= 1'b0;
      rs1_value_r    <= {XLEN{1'b0}};
      rs2_value_r    <= {XLEN{1'b0}};
      mux_result_r   <= {XLEN{1'b0}};
      opcode_r       <= 7'd0;
      funct7_r       <= 7'd0;
      rd_sel_r       <= 5'd0;
      funct3_r       <= 3'd0;
      stall_cycles_r <= {CNT_W{1'b0}};
    end else if (flush_in || (!stall_in && hazard_s)) begin
      valid_r        <= 1'b0;
      write_enable_r <= 1'b0;
      rs1_value_r    <= {XLEN{1'b0}};
      rs2_value_r    <= {XLEN{1'b0}};
      mux_result_r   <= {XLEN{1'b0}};
      opcode_r       <= 7'd0;
      funct7_r       <= 7'd0;
      rd_sel_r       <= 5'd0;
      funct3_r       <= 3'd0;
      // hazard_s is already masked by flush, so only real hazard bubbles count.
      if (hazard_s && (stall_cycles_r != {CNT_W{1'b1}})) begin
        stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
    end else if (stall_in) begin
      valid_r        <= valid_r;
      write_enable_r <= write_enable_r;
      rs1_value_r    <= rs1_value_r;
      rs2_value_r    <= rs2_value_r;
      mux_result_r   <= mux_result_r;
      opcode_r       <= opcode_r;
      funct7_r       <= funct7_r;
      rd_sel_r       <= rd_sel_r;
      funct3_r       <= funct3_r;
      stall_cycles_r <= stall_cycles_r;
    end else begin
      valid_r        <= valid_in;
      write_enable_r <= write_enable_in & valid_in;
      rs1_value_r    <= rs1_res_s[XLEN-1:0];
      rs2_value_r    <= rs2_res_s[XLEN-1:0];
      mux_result_r   <= mux_result_in;
      opcode_r       <= opcode_in;
      funct7_r       <= funct7_in;
      rd_sel_r       <= rd_sel_in;
      funct3_r       <= funct3_in;
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign valid_out        = valid_r;
  assign write_enable_out = write_enable_r;
  assign rs1_value_out    = rs1_value_r;
  assign rs2_value_out    = rs2_value_r;
  assign mux_result_out   = mux_result_r;
  assign opcode_out       = opcode_r;
  assign funct7_out       = funct7_r;
  assign rd_sel_out       = rd_sel_r;
  assign funct3_out       = funct3_r;
  assign hazard_stall_out = hazard_s;
  assign stall_cycles_out = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_reg_decode_fwd.sv
// Directed self-checking bench for pipeline_reg_decode_fwd (CNT_W = 4 to reach saturation quickly).
module tb_pipeline_reg_decode_fwd;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    stall_in;
  logic                    flush_in;
  logic                    valid_in;
  logic                    write_enable_in;
  logic [4:0]              rd_sel_in;
  logic [4:0]              rs1_sel_in;
  logic [4:0]              rs2_sel_in;
  logic [XLEN-1:0]         rs1_value_in;
  logic [XLEN-1:0]         rs2_value_in;
  logic [XLEN-1:0]         mux_result_in;
  logic [6:0]              opcode_in;
  logic [6:0]              funct7_in;
  logic [2:0]              funct3_in;
  logic [NUM_FWD-1:0]      fwd_valid_in;
  logic [NUM_FWD-1:0]      fwd_pending_in;
  logic [5*NUM_FWD-1:0]    fwd_rd_sel_in;
  logic [XLEN*NUM_FWD-1:0] fwd_value_in;
  logic                    valid_out;
  logic                    write_enable_out;
  logic [XLEN-1:0]         rs1_value_out;
  logic [XLEN-1:0]         rs2_value_out;
  logic [XLEN-1:0]         mux_result_out;
  logic [6:0]              opcode_out;
  logic [6:0]              funct7_out;
  logic [4:0]              rd_sel_out;
  logic [2:0]              funct3_out;
  logic                    hazard_stall_out;
  logic [CNT_W-1:0]        stall_cycles_out;

  int checks_cnt = 0;
  int errors_cnt = 0;

  pipeline_reg_decode_fwd #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .write_enable_in(write_enable_in),
    .rd_sel_in(rd_sel_in), .rs1_sel_in(rs1_sel_in), .rs2_sel_in(rs2_sel_in),
    .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in),
    .mux_result_in(mux_result_in), .opcode_in(opcode_in), .funct7_in(funct7_in),
    .funct3_in(funct3_in), .fwd_valid_in(fwd_valid_in), .fwd_pending_in(fwd_pending_in),
    .fwd_rd_sel_in(fwd_rd_sel_in), .fwd_value_in(fwd_value_in),
    .valid_out(valid_out), .write_enable_out(write_enable_out),
    .rs1_value_out(rs1_value_out), .rs2_value_out(rs2_value_out),
    .mux_result_out(mux_result_out), .opcode_out(opcode_out), .funct7_out(funct7_out),
    .rd_sel_out(rd_sel_out), .funct3_out(funct3_out),
    .hazard_stall_out(hazard_stall_out), .stall_cycles_out(stall_cycles_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_cnt++;
    if (observed !== expected) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0; write_enable_in = 1'b0;
    rd_sel_in = 5'd0; rs1_sel_in = 5'd0; rs2_sel_in = 5'd0;
    rs1_value_in = 32'd0; rs2_value_in = 32'd0; mux_result_in = 32'd0;
    opcode_in = 7'd0; funct7_in = 7'd0; funct3_in = 3'd0;
    fwd_valid_in = 2'b00; fwd_pending_in = 2'b00;
    fwd_rd_sel_in = 10'd0; fwd_value_in = 64'd0;
  endtask

  task automatic set_src(input int idx, input logic [4:0] rd, input logic [31:0] val,
                         input logic pend);
    fwd_valid_in[idx]          = 1'b1;
    fwd_pending_in[idx]        = pend;
    fwd_rd_sel_in[5*idx +: 5]  = rd;
    fwd_value_in[32*idx +: 32] = val;
  endtask

  initial begin
    // Reset with every input nonzero.
    rst = 1'b1; stall_in = 1'b1; flush_in = 1'b1; valid_in = 1'b1; write_enable_in = 1'b1;
    rd_sel_in = 5'd31; rs1_sel_in = 5'd1; rs2_sel_in = 5'd2;
    rs1_value_in = 32'hFFFF_FFFF; rs2_value_in = 32'hFFFF_FFFF; mux_result_in = 32'hFFFF_FFFF;
    opcode_in = 7'h7F; funct7_in = 7'h7F; funct3_in = 3'h7;
    fwd_valid_in = 2'b11; fwd_pending_in = 2'b11;
    fwd_rd_sel_in = {5'd2, 5'd1}; fwd_value_in = {32'h1111_1111, 32'h2222_2222};
    tick(); tick();
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_we", 64'(write_enable_out), 64'd0);
    check("rst_rs1", 64'(rs1_value_out), 64'd0);
    check("rst_rs2", 64'(rs2_value_out), 64'd0);
    check("rst_mux", 64'(mux_result_out), 64'd0);
    check("rst_fields", 64'({opcode_out, funct7_out, rd_sel_out, funct3_out}), 64'd0);
    check("rst_cnt", 64'(stall_cycles_out), 64'd0);
    check("rst_hazard_while_stalled", 64'(hazard_stall_out), 64'd0);
    rst = 1'b0;
    idle_inputs();

    // Both sources match rs1; the youngest (index 0) must win.
    valid_in = 1'b1; write_enable_in = 1'b1; rd_sel_in = 5'd3;
    rs1_sel_in = 5'd5; rs2_sel_in = 5'd6; rs1_value_in = 32'h11; rs2_value_in = 32'h66;
    mux_result_in = 32'h77; opcode_in = 7'h33; funct7_in = 7'h20; funct3_in = 3'd5;
    set_src(0, 5'd5, 32'hAAAA_0000, 1'b0);
    set_src(1, 5'd5, 32'h0000_5555, 1'b0);
    #1 check("prio_hazard", 64'(hazard_stall_out), 64'd0);
    tick();
    check("prio_rs1", 64'(rs1_value_out), 64'hAAAA_0000);
    check("prio_rs2_rf", 64'(rs2_value_out), 64'h66);
    check("prio_valid", 64'(valid_out), 64'd1);
    check("prio_we", 64'(write_enable_out), 64'd1);
    check("prio_mux", 64'(mux_result_out), 64'h77);
    check("prio_fields", 64'({opcode_out, funct7_out, rd_sel_out, funct3_out}),
          64'({7'h33, 7'h20, 5'd3, 3'd5}));

    // Source 0 misses, source 1 hits; invalid slot clears write enable.
    valid_in = 1'b0;
    set_src(0, 5'd9, 32'hAAAA_0000, 1'b0);
    tick();
    check("src1_rs1", 64'(rs1_value_out), 64'h5555);
    check("invalid_valid", 64'(valid_out), 64'd0);
    check("invalid_we", 64'(write_enable_out), 64'd0);

    // x0 is never forwarded.
    idle_inputs();
    valid_in = 1'b1; rs2_sel_in = 5'd0; rs2_value_in = 32'd0;
    set_src(0, 5'd0, 32'h1234, 1'b0);
    #1 check("x0_hazard", 64'(hazard_stall_out), 64'd0);
    tick();
    check("x0_rs2", 64'(rs2_value_out), 64'd0);

    // Load-use on rs2: pending youngest match blocks the ready older one.
    idle_inputs();
    valid_in = 1'b1; write_enable_in = 1'b1; rd_sel_in = 5'd8;
    rs2_sel_in = 5'd7; rs2_value_in = 32'h77;
    set_src(0, 5'd7, 32'hBEEF, 1'b1);
    set_src(1, 5'd7, 32'h1111, 1'b0);
    #1 check("lu_hazard_on", 64'(hazard_stall_out), 64'd1);
    tick();
    check("lu_bubble_valid", 64'(valid_out), 64'd0);
    check("lu_bubble_rs2", 64'(rs2_value_out), 64'd0);
    check("lu_cnt_1", 64'(stall_cycles_out), 64'd1);
    set_src(0, 5'd7, 32'hDEAD, 1'b0);
    #1 check("lu_hazard_off", 64'(hazard_stall_out), 64'd0);
    tick();
    check("lu_rs2_fwd", 64'(rs2_value_out), 64'hDEAD);
    check("lu_valid", 64'(valid_out), 64'd1);
    check("lu_rd", 64'(rd_sel_out), 64'd8);
    check("lu_cnt_hold", 64'(stall_cycles_out), 64'd1);

    // Hold for 3 cycles with a pending hazard and new fields present.
    stall_in = 1'b1; rd_sel_in = 5'd20; opcode_in = 7'h13; mux_result_in = 32'h9999;
    set_src(0, 5'd7, 32'hDEAD, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_hazard_masked", 64'(hazard_stall_out), 64'd0);
      tick();
      check("stall_rs2_held", 64'(rs2_value_out), 64'hDEAD);
      check("stall_valid_held", 64'(valid_out), 64'd1);
    end
    check("stall_rd_held", 64'(rd_sel_out), 64'd8);
    check("stall_mux_held", 64'(mux_result_out), 64'd0);
    check("stall_cnt", 64'(stall_cycles_out), 64'd1);

    // Flush beats a pending hazard: bubble, no request, counter unchanged.
    stall_in = 1'b0; flush_in = 1'b1;
    #1 check("flush_hazard_masked", 64'(hazard_stall_out), 64'd0);
    tick();
    check("flush_valid", 64'(valid_out), 64'd0);
    check("flush_rs2", 64'(rs2_value_out), 64'd0);
    check("flush_cnt", 64'(stall_cycles_out), 64'd1);
    flush_in = 1'b0;

    // Both operands hazarding at once count as one bubble.
    rs1_sel_in = 5'd7;
    #1 check("dual_hazard", 64'(hazard_stall_out), 64'd1);
    tick();
    check("dual_cnt", 64'(stall_cycles_out), 64'd2);

    // Saturation: 20 more hazard cycles take the 4-bit counter to 15 and keep it there.
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt", 64'(stall_cycles_out), 64'd15);
    tick();
    check("sat_cnt_stays", 64'(stall_cycles_out), 64'd15);
    flush_in = 1'b1;
    tick();
    check("flush_keeps_cnt", 64'(stall_cycles_out), 64'd15);

    // Reset during a stall clears outputs; the request follows the live inputs.
    flush_in = 1'b0; stall_in = 1'b1; rst = 1'b1;
    tick();
    check("rst_mid_stall_cnt", 64'(stall_cycles_out), 64'd0);
    check("rst_mid_stall_valid", 64'(valid_out), 64'd0);
    stall_in = 1'b0;
    #1 check("rst_hazard_eq", 64'(hazard_stall_out), 64'd1);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_reg_decode_fwd.md
# pipeline_reg_decode_fwd

Parametrised decode-to-execute pipeline register with built-in operand forwarding for both source operands, bubble insertion on load-use hazards, external stall/flush control, and a saturating hazard-stall counter. It sits between the decoder/register file and the ALU stage. It generalises the single-operand, single-source decode register to N priority-ordered forwarding sources and a valid-qualified pipeline slot.

## Interface
Parameters:
- XLEN, 32, datapath width of operand/result values
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest and has the highest priority
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- stall_in  in  1  downstream stall; hold all registered outputs
- flush_in  in  1  squash; load a bubble
- valid_in  in  1  incoming decode slot holds a real instruction
- write_enable_in  in  1  instruction writes rd
- rd_sel_in, rs1_sel_in, rs2_sel_in  in  5 each  register indices
- rs1_value_in, rs2_value_in  in  XLEN each  register-file read data
- mux_result_in  in  XLEN  immediate/operand-B mux result
- opcode_in  in  7; funct7_in  in  7; funct3_in  in  3  decode fields
- fwd_valid_in  in  NUM_FWD  source i carries a register write
- fwd_pending_in  in  NUM_FWD  source i result not yet available (load in flight)
- fwd_rd_sel_in  in  5*NUM_FWD  destination index of source i, at bits [5i+4:5i]
- fwd_value_in  in  XLEN*NUM_FWD  result of source i, at bits [XLEN*i+XLEN-1:XLEN*i]
- valid_out, write_enable_out  out  1
- rs1_value_out, rs2_value_out, mux_result_out  out  XLEN
- opcode_out, funct7_out  out  7; rd_sel_out  out  5; funct3_out  out  3
- hazard_stall_out  out  1  combinational request to freeze the fetch and decode stages
- stall_cycles_out  out  CNT_W  saturating count of inserted hazard bubbles

## Operation
- Operand resolution, per operand rsX, combinational:
  - If sel = 0, use the register-file value and never forward.
  - Otherwise, choose the lowest index i with fwd_valid_in[i] and fwd_rd_sel_in[i] = sel.
  - If a match i exists and fwd_pending_in[i] = 0, use fwd_value_in[i]. If no match exists, use the register-file value.
  - If the match has fwd_pending_in[i] = 1, rsX is a load-use hazard. Lower-priority matches are ignored even when ready.
- hazard_stall_out = valid_in & ~flush_in & ~stall_in & (hazard on rs1 | hazard on rs2).
- Register update priority at each rising edge:
  1. rst: all outputs 0.
  2. flush_in: load a bubble. valid_out = 0, write_enable_out = 0, all other outputs = 0.
  3. stall_in: hold every output unchanged. No forwarding re-evaluation occurs.
  4. hazard_stall_out: load a bubble, same as flush, and increment the counter.
  5. Otherwise: load all fields. rs1/rs2 take the resolved values, valid_out = valid_in, and write_enable_out = write_enable_in & valid_in.
- stall_cycles_out increments by 1 on every edge in case 4 and saturates at 2^CNT_W-1. It clears only on rst; flush does not clear it.

## Timing
- Latency is one cycle from the decode inputs to the registered outputs. Forwarding adds no cycles.
- hazard_stall_out has zero latency: it is asserted in the same cycle as the offending inputs. The upstream stage must hold valid_in and all its fields while hazard_stall_out = 1.
- Load-use sequence: the hazard is seen in cycle n, a bubble is emitted at edge n+1, and pending drops in cycle n+1. The instruction is then loaded with the forwarded value at edge n+2.
- Simultaneous flush_in and hazard: flush wins. No stall request is raised and the counter does not increment.
- Simultaneous stall_in and hazard: hold wins. hazard_stall_out = 0 and the counter is unchanged.
- Both operands hazarding in the same cycle produce one bubble and one increment.
- Reset asserted mid-stall: outputs are 0 after that edge and hazard_stall_out follows its equation with the current inputs.
- The counter at max stays at max.

## Test plan
- Reset: assert rst for 2 cycles with all inputs nonzero -> every output is 0, including stall_cycles_out = 0.
- Priority forward: rs1_sel = 5; source 0 has rd 5, value 0xAAAA0000; source 1 has rd 5, value 0x5555; both valid, not pending -> rs1_value_out = 0xAAAA0000 after one edge.
- x0 guard: rs2_sel = 0, rs2_value_in = 0, source 0 has rd 0, value 0x1234 -> rs2_value_out = 0.
- Load-use: rs2_sel = 7; source 0 has rd 7 and is pending for 1 cycle, then ready with 0xDEAD -> hazard_stall_out is high for exactly 1 cycle; one bubble appears (valid_out = 0); the next edge gives rs2_value_out = 0xDEAD; stall_cycles_out = 1.
- Stall/flush ordering:
  - stall_in held 3 cycles -> outputs unchanged.
  - flush_in together with a pending hazard -> bubble, hazard_stall_out = 0, counter unchanged.
- Saturation: CNT_W = 4 with 20 consecutive hazard cycles -> stall_cycles_out = 15 and it stays at 15.
